mem_bus_responder: RTL and testbench
====================================

// Module: mem_bus_responder
// PURPOSE
//   Memory-side responder for the control unit's mem_read/mem_write strobes. Captures
//   address/data on a strobe, runs a timed access cycle to an external byte-wide async
//   SRAM, returns read data and asserts stall so the control sequencer holds its phase.
//   Sits between the datapath abus/dbus and the SRAM pins.
// PARAMETERS
//   ADDR_W       16  address width (abus and sram_addr)
//   DATA_W       8   data width (byte-wide memory)
//   WAIT_STATES  2   extra cycles the SRAM strobe is held (0..15)
// PORTS
//   clk         in   1       system clock, all state on rising edge
//   reset       in   1       reset, asynchronous, active-high
//   mem_read    in   1       read request strobe from control unit
//   mem_write   in   1       write request strobe from control unit
//   abus        in   ADDR_W  access address
//   wdata       in   DATA_W  write data (dbus low byte)
//   rdata       out  DATA_W  read data to datapath
//   rdata_valid out  1       rdata valid, 1-cycle pulse
//   stall       out  1       access in progress; control unit must hold phase
//   bus_err     out  1       1-cycle pulse: mem_read and mem_write both high
//   sram_addr   out  ADDR_W  SRAM address
//   sram_wdata  out  DATA_W  SRAM write data
//   sram_rdata  in   DATA_W  SRAM read data
//   sram_ce_n   out  1       SRAM chip enable, active-low
//   sram_oe_n   out  1       SRAM output enable, active-low
//   sram_we_n   out  1       SRAM write enable, active-low
// BEHAVIOUR
//   - Reset: state IDLE; rdata=0, rdata_valid=0, stall=0, bus_err=0, sram_addr=0,
//     sram_wdata=0, sram_ce_n=1, sram_oe_n=1, sram_we_n=1, wait counter=0.
//   - Requests sampled only in IDLE; abus/wdata latched at acceptance edge, later
//     input changes ignored until return to IDLE.
//   - Both strobes high in IDLE: no access, bus_err=1 for one cycle, stay IDLE.
//   - States: IDLE, RD_ACT, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD.
//   - Read: IDLE->RD_ACT (ce_n=0, oe_n=0, counter=WAIT_STATES); RD_ACT decrements
//     until 0, then samples sram_rdata into rdata -> RD_DONE; RD_DONE: rdata_valid=1,
//     stall=0, ce_n/oe_n=1 -> IDLE. Read latency = WAIT_STATES+2 clocks from acceptance.
//   - Write: IDLE->WR_SETUP (ce_n=0, addr/wdata driven, we_n=1) -> WR_PULSE (we_n=0,
//     held WAIT_STATES+1 cycles) -> WR_HOLD (we_n=1, ce_n=0, addr/data stable) -> IDLE.
//     Write latency = WAIT_STATES+3 clocks; we_n never low while addr changes.
//   - stall: high from cycle after acceptance through last non-DONE state; low in
//     RD_DONE, WR_HOLD exit cycle and IDLE. Combinationally also high in IDLE when a
//     strobe is present (so the sequencer cannot advance on acceptance edge).
//   - oe_n and we_n never both low. rdata holds last read value until next read.
//   - Back-to-back: new strobe accepted on first IDLE cycle; no turnaround needed
//     after write, one IDLE cycle forced after read before a write (bus turnaround).
//   - Counter width 4 bits; WAIT_STATES=0 gives 1-cycle RD_ACT and 1-cycle WR_PULSE.
//   - Reset mid-access: immediate return to reset values; SRAM pins deasserted
//     asynchronously, partial write abandoned, no rdata_valid.
// TESTING
//   - Reset: assert reset mid-WR_PULSE -> we_n=1, ce_n=1, stall=0 same cycle; no
//     further SRAM activity after release without a new strobe.
//   - Read, WAIT_STATES=2: abus=16'h1234, sram_rdata=8'hA5 -> oe_n low 3 cycles,
//     rdata=8'hA5 with rdata_valid at acceptance+4, stall high until then.
//   - Write, WAIT_STATES=2: abus=16'h00FF, wdata=8'h5A -> we_n low exactly 3 cycles,
//     addr/data stable one cycle before and after we_n low; total 5 cycles.
//   - Conflict: mem_read=mem_write=1 -> bus_err pulse, ce_n stays 1, stall low after.
//   - Back-to-back read then write -> one IDLE gap inserted; write then read -> none;
//     abus changed mid-access does not alter sram_addr.
//   - WAIT_STATES=0 build: read latency 2, write latency 3, oe_n/we_n never overlap.

Source files
------------

// File: rtl/mem_bus_responder.sv
// Memory-side responder: turns control-unit mem_read/mem_write strobes into timed
// accesses on a byte-wide async SRAM and holds the sequencer with stall meanwhile.
module mem_bus_responder #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] abus,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              stall,
    output logic              bus_err,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ACT,
        RD_DONE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_stall;
    logic       r_turnaround;

    logic w_strobe;
    logic w_idle;

    assign w_strobe = mem_read | mem_write;
    assign w_idle   = (r_state == IDLE);

    // The sequencer must not advance on the acceptance edge, so stall is raised
    // combinationally as soon as a strobe is seen in IDLE.
    assign stall = r_stall | (w_idle & w_strobe & ~reset);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_stall      <= 1'b0;
            r_turnaround <= 1'b0;
            rdata        <= '0;
            rdata_valid  <= 1'b0;
            bus_err      <= 1'b0;
            sram_addr    <= '0;
            sram_wdata   <= '0;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
        end else begin
            rdata_valid <= 1'b0;
            bus_err     <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_turnaround <= 1'b0;
                    if (mem_read && mem_write) begin
                        bus_err <= 1'b1;
                    end else if (mem_read) begin
                        r_state   <= RD_ACT;
                        r_cnt     <= WS;
                        r_stall   <= 1'b1;
                        sram_addr <= abus;
                        sram_ce_n <= 1'b0;
                        sram_oe_n <= 1'b0;
                    end else if (mem_write && !r_turnaround) begin
                        // A write straight after a read waits one IDLE cycle so the
                        // SRAM has released the data bus before we drive it.
                        r_state    <= WR_SETUP;
                        r_stall    <= 1'b1;
                        sram_addr  <= abus;
                        sram_wdata <= wdata;
                        sram_ce_n  <= 1'b0;
                    end
                end
                RD_ACT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= RD_DONE;
                        rdata       <= sram_rdata;
                        rdata_valid <= 1'b1;
                        r_stall     <= 1'b0;
                        sram_ce_n   <= 1'b1;
                        sram_oe_n   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RD_DONE: begin
                    r_state      <= IDLE;
                    r_turnaround <= 1'b1;
                end
                WR_SETUP: begin
                    r_state   <= WR_PULSE;
                    r_cnt     <= WS;
                    sram_we_n <= 1'b0;
                end
                WR_PULSE: begin
                    if (r_cnt == 4'd0) begin
                        r_state   <= WR_HOLD;
                        r_stall   <= 1'b0;
                        sram_we_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                WR_HOLD: begin
                    r_state   <= IDLE;
                    sram_ce_n <= 1'b1;
                end
                default: begin
                    r_state   <= IDLE;
                    r_stall   <= 1'b0;
                    sram_ce_n <= 1'b1;
                    sram_oe_n <= 1'b1;
                    sram_we_n <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: a WAIT_STATES=2 and a WAIT_STATES=0 instance are
// compared every cycle against a transaction-schedule model, plus literal timing pins.
module tb_mem_bus_responder;
    localparam int AW = 16;
    localparam int DW = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic          mem_read    [2];
    logic          mem_write   [2];
    logic [AW-1:0] abus        [2];
    logic [DW-1:0] wdata       [2];
    logic [DW-1:0] rdata       [2];
    logic          rdata_valid [2];
    logic          stall       [2];
    logic          bus_err     [2];
    logic [AW-1:0] sram_addr   [2];
    logic [DW-1:0] sram_wdata  [2];
    logic [DW-1:0] sram_rdata  [2];
    logic          sram_ce_n   [2];
    logic          sram_oe_n   [2];
    logic          sram_we_n   [2];

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(int k, int i);
        if (i == 8'h34) return 8'hA5;
        return 8'(i * 37 + k * 11 + 92);
    endfunction

    function automatic int ws_of(int k);
        return (k == 0) ? 2 : 0;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        logic [DW-1:0] sram_mem [256];
        bit            sram_wr  [256];
        wire  [7:0]    w_idx = sram_addr[gi][7:0];

        mem_bus_responder #(
            .ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(gi == 0 ? 2 : 0)
        ) u_dut (
            .clk(clk), .reset(reset),
            .mem_read(mem_read[gi]), .mem_write(mem_write[gi]),
            .abus(abus[gi]), .wdata(wdata[gi]),
            .rdata(rdata[gi]), .rdata_valid(rdata_valid[gi]),
            .stall(stall[gi]), .bus_err(bus_err[gi]),
            .sram_addr(sram_addr[gi]), .sram_wdata(sram_wdata[gi]),
            .sram_rdata(sram_rdata[gi]),
            .sram_ce_n(sram_ce_n[gi]), .sram_oe_n(sram_oe_n[gi]), .sram_we_n(sram_we_n[gi])
        );

        // SRAM drives junk whenever its outputs are disabled.
        assign sram_rdata[gi] = sram_oe_n[gi] ? 8'hEE :
                                (sram_wr[w_idx] ? sram_mem[w_idx] : init_val(gi, w_idx));

        always @(posedge clk)
            if (!reset && !sram_ce_n[gi] && !sram_we_n[gi]) begin
                sram_mem[w_idx] <= sram_wdata[gi];
                sram_wr[w_idx]  <= 1'b1;
            end
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit rst_req  = 1'b1;

    bit            req_rd [2];
    bit            req_wr [2];
    logic [AW-1:0] req_a  [2];
    logic [DW-1:0] req_d  [2];

    bit            op_v [2];
    bit            op_rd [2];
    bit            idle_now [2];
    int            op_t [2];
    int            acc_t [2];
    int            rd_end [2];
    int            berr_t [2];
    logic [AW-1:0] op_addr [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] op_data [2];
    logic [DW-1:0] m_wdata [2];
    logic [DW-1:0] m_rdata [2];
    logic [DW-1:0] mdl_mem [2][256];

    int oe_lo [2];
    int we_lo [2];
    int ce_lo [2];
    int be_cnt [2];
    int valid_t [2];
    int hi_run [2];
    int last_gap [2];

    task automatic chk(string name, int k, logic [31:0] act, logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s inst%0d cyc=%0d actual=%0h required=%0h", name, k, cyc, act, want);
        end
    endtask

    // Expected pins are derived from where the cycle falls inside the accepted
    // transaction's timeline (offset n from the acceptance cycle).
    task automatic model_check(int k);
        logic e_ce = 1'b1;
        logic e_oe = 1'b1;
        logic e_we = 1'b1;
        logic e_st = 1'b0;
        logic e_vl = 1'b0;
        logic e_be = 1'b0;
        int   n;
        idle_now[k] = 1'b0;
        if (reset) begin
            op_v[k] = 1'b0; rd_end[k] = -100; berr_t[k] = -100;
            m_addr[k] = '0; m_wdata[k] = '0; m_rdata[k] = '0;
            req_rd[k] = 1'b0; req_wr[k] = 1'b0;
        end else begin
            e_be = (berr_t[k] == cyc);
            if (op_v[k]) begin
                n = cyc - op_t[k];
                if (op_rd[k]) begin
                    if (n <= ws_of(k) + 1) begin
                        e_ce = 1'b0; e_oe = 1'b0; e_st = 1'b1;
                    end else begin
                        e_vl = 1'b1;
                        m_rdata[k] = mdl_mem[k][op_addr[k][7:0]];
                        op_v[k] = 1'b0; rd_end[k] = cyc;
                    end
                end else begin
                    if (n == 1) begin
                        e_ce = 1'b0; e_st = 1'b1;
                    end else if (n <= ws_of(k) + 2) begin
                        e_ce = 1'b0; e_we = 1'b0; e_st = 1'b1;
                    end else begin
                        e_ce = 1'b0;
                        mdl_mem[k][op_addr[k][7:0]] = op_data[k];
                        op_v[k] = 1'b0;
                    end
                end
            end else begin
                idle_now[k] = 1'b1;
                e_st = req_rd[k] | req_wr[k];
            end
        end
        chk("ce_n", k, 32'(sram_ce_n[k]), 32'(e_ce));
        chk("oe_n", k, 32'(sram_oe_n[k]), 32'(e_oe));
        chk("we_n", k, 32'(sram_we_n[k]), 32'(e_we));
        chk("stall", k, 32'(stall[k]), 32'(e_st));
        chk("rdata_valid", k, 32'(rdata_valid[k]), 32'(e_vl));
        chk("bus_err", k, 32'(bus_err[k]), 32'(e_be));
        chk("rdata", k, 32'(rdata[k]), 32'(m_rdata[k]));
        chk("sram_addr", k, 32'(sram_addr[k]), 32'(m_addr[k]));
        chk("sram_wdata", k, 32'(sram_wdata[k]), 32'(m_wdata[k]));
    endtask

    task automatic model_accept(int k);
        if (!reset && idle_now[k]) begin
            if (req_rd[k] && req_wr[k]) begin
                berr_t[k] = cyc + 1;
                $display("inst%0d cyc=%0d conflict addr=%h", k, cyc, req_a[k]);
                req_rd[k] = 1'b0; req_wr[k] = 1'b0;
            end else if (req_rd[k] || (req_wr[k] && rd_end[k] != cyc - 1)) begin
                op_v[k] = 1'b1; op_rd[k] = req_rd[k]; op_t[k] = cyc; acc_t[k] = cyc;
                op_addr[k] = req_a[k]; op_data[k] = req_d[k]; m_addr[k] = req_a[k];
                if (!req_rd[k]) m_wdata[k] = req_d[k];
                $display("inst%0d cyc=%0d %s addr=%h wdata=%h", k, cyc,
                         req_rd[k] ? "read " : "write", req_a[k], req_d[k]);
                req_rd[k] = 1'b0; req_wr[k] = 1'b0;
            end
        end
    endtask

    task automatic measure(int k);
        if (!sram_oe_n[k]) oe_lo[k]++;
        if (!sram_we_n[k]) we_lo[k]++;
        if (!sram_ce_n[k]) ce_lo[k]++;
        if (bus_err[k]) be_cnt[k]++;
        if (rdata_valid[k]) valid_t[k] = cyc;
        if (sram_ce_n[k]) begin
            hi_run[k]++;
        end else begin
            if (hi_run[k] > 0) last_gap[k] = hi_run[k];
            hi_run[k] = 0;
        end
    endtask

    task automatic clear_meas();
        for (int k = 0; k < 2; k++) begin
            oe_lo[k] = 0; we_lo[k] = 0; ce_lo[k] = 0; be_cnt[k] = 0;
            valid_t[k] = -1; hi_run[k] = 0; last_gap[k] = -1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        reset = rst_req;
        for (int k = 0; k < 2; k++) begin
            mem_read[k]  = req_rd[k];
            mem_write[k] = req_wr[k];
            if (req_rd[k] || req_wr[k]) begin
                abus[k] = req_a[k]; wdata[k] = req_d[k];
            end else begin
                abus[k] = 16'($urandom); wdata[k] = 8'($urandom);
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            model_check(k);
            measure(k);
        end
        for (int k = 0; k < 2; k++) model_accept(k);
    endtask

    task automatic issue(bit rd, bit wr, logic [AW-1:0] a, logic [DW-1:0] d);
        for (int k = 0; k < 2; k++) begin
            req_rd[k] = rd; req_wr[k] = wr; req_a[k] = a; req_d[k] = d;
        end
    endtask

    task automatic run_idle();
        int i = 0;
        while ((op_v[0] || op_v[1] || req_rd[0] || req_wr[0] || req_rd[1] || req_wr[1]) && i < 200) begin
            step();
            i++;
        end
        chk("drain_timeout", 0, 32'(i < 200), 32'd1);
        step();
    endtask

    // Second request is raised the cycle after the first is accepted.
    task automatic pair(bit rd1, logic [AW-1:0] a1, logic [DW-1:0] d1,
                        bit rd2, logic [AW-1:0] a2, logic [DW-1:0] d2);
        bit sent [2];
        sent = '{1'b0, 1'b0};
        issue(rd1, !rd1, a1, d1);
        for (int i = 0; i < 50 && !(sent[0] && sent[1]); i++) begin
            step();
            for (int k = 0; k < 2; k++)
                if (!sent[k] && !req_rd[k] && !req_wr[k]) begin
                    req_rd[k] = rd2; req_wr[k] = !rd2; req_a[k] = a2; req_d[k] = d2;
                    sent[k] = 1'b1;
                end
        end
        run_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            mem_read[k] = 1'b0; mem_write[k] = 1'b0; abus[k] = '0; wdata[k] = '0;
            req_rd[k] = 1'b0; req_wr[k] = 1'b0; req_a[k] = '0; req_d[k] = '0;
            op_v[k] = 1'b0; rd_end[k] = -100; berr_t[k] = -100; acc_t[k] = 0;
            m_addr[k] = '0; m_wdata[k] = '0; m_rdata[k] = '0;
            for (int i = 0; i < 256; i++) mdl_mem[k][i] = init_val(k, i);
        end
        clear_meas();

        repeat (3) step();
        for (int k = 0; k < 2; k++) begin
            chk("reset_ce_n", k, 32'(sram_ce_n[k]), 32'd1);
            chk("reset_stall", k, 32'(stall[k]), 32'd0);
            chk("reset_rdata", k, 32'(rdata[k]), 32'd0);
        end
        rst_req = 1'b0;
        repeat (2) step();

        clear_meas();
        issue(1'b1, 1'b0, 16'h1234, 8'h00);
        run_idle();
        chk("read_latency", 0, 32'(valid_t[0] - acc_t[0]), 32'd4);
        chk("read_latency", 1, 32'(valid_t[1] - acc_t[1]), 32'd2);
        chk("read_oe_low", 0, 32'(oe_lo[0]), 32'd3);
        chk("read_oe_low", 1, 32'(oe_lo[1]), 32'd1);
        chk("read_data", 0, 32'(rdata[0]), 32'hA5);
        chk("read_data", 1, 32'(rdata[1]), 32'hA5);

        clear_meas();
        issue(1'b0, 1'b1, 16'h00FF, 8'h5A);
        run_idle();
        chk("write_we_low", 0, 32'(we_lo[0]), 32'd3);
        chk("write_we_low", 1, 32'(we_lo[1]), 32'd1);
        chk("write_ce_low", 0, 32'(ce_lo[0]), 32'd5);
        chk("write_ce_low", 1, 32'(ce_lo[1]), 32'd3);
        chk("write_oe_low", 0, 32'(oe_lo[0]), 32'd0);

        issue(1'b1, 1'b0, 16'h00FF, 8'h00);
        run_idle();
        chk("readback", 0, 32'(rdata[0]), 32'h5A);
        chk("readback", 1, 32'(rdata[1]), 32'h5A);

        clear_meas();
        issue(1'b1, 1'b1, 16'h4321, 8'h77);
        run_idle();
        for (int k = 0; k < 2; k++) begin
            chk("conflict_bus_err", k, 32'(be_cnt[k]), 32'd1);
            chk("conflict_ce_low", k, 32'(ce_lo[k]), 32'd0);
            chk("conflict_stall", k, 32'(stall[k]), 32'd0);
        end

        clear_meas();
        pair(1'b1, 16'h0102, 8'h00, 1'b0, 16'h0304, 8'h3C);
        chk("rd_wr_gap", 0, 32'(last_gap[0]), 32'd3);
        chk("rd_wr_gap", 1, 32'(last_gap[1]), 32'd3);

        clear_meas();
        pair(1'b0, 16'h0506, 8'hC3, 1'b1, 16'h0506, 8'h00);
        chk("wr_rd_gap", 0, 32'(last_gap[0]), 32'd1);
        chk("wr_rd_gap", 1, 32'(last_gap[1]), 32'd1);
        chk("wr_rd_data", 0, 32'(rdata[0]), 32'hC3);

        issue(1'b0, 1'b1, 16'hBEEF, 8'h99);
        for (int i = 0; i < 20 && req_wr[0]; i++) step();
        step();
        @(posedge clk);
        #1;
        chk("pulse_before_reset", 0, 32'(sram_we_n[0]), 32'd0);
        #1;
        reset = 1'b1;
        rst_req = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async_reset_we_n", k, 32'(sram_we_n[k]), 32'd1);
            chk("async_reset_ce_n", k, 32'(sram_ce_n[k]), 32'd1);
            chk("async_reset_stall", k, 32'(stall[k]), 32'd0);
        end
        repeat (2) step();
        rst_req = 1'b0;
        clear_meas();
        repeat (10) step();
        chk("post_reset_quiet", 0, 32'(ce_lo[0]), 32'd0);
        chk("post_reset_quiet", 1, 32'(ce_lo[1]), 32'd0);

        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++)
                if (!req_rd[k] && !req_wr[k] && $urandom_range(0, 2) == 0) begin
                    int r;
                    r = $urandom_range(0, 9);
                    req_rd[k] = (r < 5) || (r == 9);
                    req_wr[k] = (r >= 5);
                    req_a[k]  = 16'($urandom);
                    req_d[k]  = 8'($urandom);
                end
            step();
        end
        run_idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
